// File: rtl/des_pkg.sv
// Shared DES datapath constants and the output serializer state encoding.
package des_pkg;
  localparam int DES_BLOCK_W     = 64;
  localparam int DES_BLOCK_BYTES = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;
endpackage

// File: rtl/des_output_serializer.sv
// Captures a DES block on the rising edge of data_out and streams it MSB byte first, first byte valid one cycle after capture;
// holds tx_data/tx_valid while tx_ready is low. Optional tx_last framing output under DES_SER_LAST_FLAG_EN.
module des_output_serializer
  import des_pkg::*;
#(
  parameter int BYTES = DES_BLOCK_BYTES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   data_out,
  input  logic [DES_BLOCK_W-1:0] des_result,
  output logic                   empty,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
`ifdef DES_SER_LAST_FLAG_EN
  output logic                   tx_last,
`endif
  output logic [7:0]             block_cnt
);

  localparam int CNT_W = $clog2(BYTES);

  ser_state_t             state;
  logic [DES_BLOCK_W-1:0] shift;
  logic [CNT_W-1:0]       byte_cnt;
  logic                   data_out_q;
  logic                   start;
  logic                   last_byte;

  assign start     = data_out & ~data_out_q;
  assign last_byte = (byte_cnt == CNT_W'(BYTES - 1));

  // Low in the very cycle data_out rises, so the controller cannot leave
  // DATA_READY before the block has been captured.
  assign empty   = (state == IDLE) & ~start;
  assign tx_data = shift[DES_BLOCK_W-1 -: 8];

`ifdef DES_SER_LAST_FLAG_EN
  assign tx_last = tx_valid & last_byte;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      byte_cnt   <= '0;
      data_out_q <= 1'b0;
      tx_valid   <= 1'b0;
      block_cnt  <= 8'd0;
    end else begin
      data_out_q <= data_out;
      case (state)
        IDLE: begin
          if (start) begin
            shift    <= des_result;
            byte_cnt <= '0;
            tx_valid <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          // data_out is deliberately ignored here: a started block always drains fully.
          if (tx_ready) begin
            shift    <= {shift[DES_BLOCK_W-9:0], 8'h00};
            byte_cnt <= byte_cnt + 1'b1;
            if (last_byte) begin
              tx_valid  <= 1'b0;
              block_cnt <= block_cnt + 8'd1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
